fpu_op_sequencer: RTL and testbench

//  Issue/writeback sequencer for the combinational FP coprocessor (coprocessor1).

---
 rtl/fpu_op_sequencer.sv | 133 +++++++++++++
 tb/tb_fpu_op_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer.sv
// Issue/writeback sequencer for the combinational FP coprocessor.
// Accepts one FP op at a time from decode and registers its operands and opcode onto the FPU
// inputs. After LATENCY cycles it captures the FPU result and offers it to the FP register-file
// writeback port. It also reports when a decode read register matches the in-flight destination.
//
// Ports:
//   i_clk, i_reset          clock (rising edge), asynchronous active-high reset
//   i_req_*, o_req_ready    op request handshake: opcode, operands, destination register
//   i_flush                 discard any op that has not yet reached writeback
//   o_fpu_data1/2, o_fpu_op registered FPU inputs; i_fpu_res is the FPU result
//   o_wb_*, i_wb_ready      writeback handshake: result and destination register
//   i_chk_reg, o_chk_hazard hazard query from decode
//   o_busy, o_op_count      sequencer not idle; count of completed writebacks (wraps)
module fpu_op_sequencer #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_req_op,
  input  logic [31:0]      i_req_a,
  input  logic [31:0]      i_req_b,
  input  logic [4:0]       i_req_fd,
  input  logic             i_flush,
  output logic [31:0]      o_fpu_data1,
  output logic [31:0]      o_fpu_data2,
  output logic [2:0]       o_fpu_op,
  input  logic [31:0]      i_fpu_res,
  output logic             o_wb_valid,
  input  logic             i_wb_ready,
  output logic [31:0]      o_wb_data,
  output logic [4:0]       o_wb_fd,
  input  logic [4:0]       i_chk_reg,
  output logic             o_chk_hazard,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_t;

  localparam logic [3:0] WaitInit = 4'(LATENCY - 1);

  state_t           r_state;
  logic [3:0]       r_wait;
  logic [4:0]       r_pend_fd;
  logic [31:0]      r_fpu_data1;
  logic [31:0]      r_fpu_data2;
  logic [2:0]       r_fpu_op;
  logic             r_wb_valid;
  logic [31:0]      r_wb_data;
  logic [4:0]       r_wb_fd;
  logic [CNT_W-1:0] r_op_count;

  logic w_req_ready;
  logic w_accept;

  // A new op may enter from IDLE, or from WB in the same cycle the current result retires.
  always_comb begin
    w_req_ready = 1'b0;
    if (!i_flush) begin
      w_req_ready = (r_state == StIdle) || ((r_state == StWb) && i_wb_ready);
    end
  end

  assign w_accept = i_req_valid && w_req_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_wait      <= 4'd0;
      r_pend_fd   <= 5'd0;
      r_fpu_data1 <= 32'd0;
      r_fpu_data2 <= 32'd0;
      r_fpu_op    <= 3'd0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= 32'd0;
      r_wb_fd     <= 5'd0;
      r_op_count  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state <= StExec;
          end
        end
        StExec: begin
          if (i_flush) begin
            r_state <= StIdle;
          end else if (r_wait == 4'd0) begin
            r_wb_data  <= i_fpu_res;
            r_wb_fd    <= r_pend_fd;
            r_wb_valid <= 1'b1;
            r_state    <= StWb;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        StWb: begin
          // Flush does not cancel a result that already reached writeback.
          if (i_wb_ready) begin
            r_wb_valid <= 1'b0;
            r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state    <= w_accept ? StExec : StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase

      // Operand capture shared by the IDLE and back-to-back WB acceptance paths.
      if (w_accept) begin
        r_fpu_data1 <= i_req_a;
        r_fpu_data2 <= i_req_b;
        r_fpu_op    <= i_req_op;
        r_pend_fd   <= i_req_fd;
        r_wait      <= WaitInit;
      end
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_fpu_data1  = r_fpu_data1;
  assign o_fpu_data2  = r_fpu_data2;
  assign o_fpu_op     = r_fpu_op;
  assign o_wb_valid   = r_wb_valid;
  assign o_wb_data    = r_wb_data;
  assign o_wb_fd      = r_wb_fd;
  assign o_busy       = (r_state != StIdle);
  assign o_chk_hazard = o_busy && (i_chk_reg == r_pend_fd);
  assign o_op_count   = r_op_count;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: transaction-level model plus directed scenarios.
module tb_fpu_op_sequencer;

  localparam int unsigned LAT = 2;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [31:0]   req_a = 32'd0;
  logic [31:0]   req_b = 32'd0;
  logic [4:0]    req_fd = 5'd0;
  logic          flush = 1'b0;
  logic [31:0]   fpu_data1, fpu_data2;
  logic [2:0]    fpu_op;
  logic [31:0]   fpu_res;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [31:0]   wb_data;
  logic [4:0]    wb_fd;
  logic [4:0]    chk_reg = 5'd0;
  logic          chk_hazard, busy;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  fpu_op_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_fd(req_fd), .i_flush(flush),
    .o_fpu_data1(fpu_data1), .o_fpu_data2(fpu_data2), .o_fpu_op(fpu_op),
    .i_fpu_res(fpu_res),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_data(wb_data), .o_wb_fd(wb_fd),
    .i_chk_reg(chk_reg), .o_chk_hazard(chk_hazard), .o_busy(busy), .o_op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stand-in coprocessor: op0 is a table of known IEEE sums, other ops a scramble.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    if (op == 3'd0) begin
      if (a == 32'h42C80000 && b == 32'h41C80000) return 32'h42FA0000;
      if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
      if (a == 32'hC1B80000 && b == 32'hC5AF3800) return 32'hC5AFF000;
      return a ^ b;
    end
    return a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
  endfunction

  // Result is garbage until the inputs have been stable for long enough.
  logic [66:0] stub_last = '0;
  int          stub_age = 0;
  always @(negedge clk) begin
    if ({fpu_data1, fpu_data2, fpu_op} != stub_last) begin
      stub_last <= {fpu_data1, fpu_data2, fpu_op};
      stub_age  <= 0;
    end else if (stub_age < 100) begin
      stub_age <= stub_age + 1;
    end
  end
  assign fpu_res = (stub_age >= int'(LAT) - 1) ? fpu_fn(fpu_data1, fpu_data2, fpu_op)
                                               : 32'hDEADBEEF;

  // Transaction model: one op in flight, ages from acceptance, done after LAT cycles.
  bit            m_busy, m_done;
  int            m_age;
  logic [31:0]   m_a, m_b, m_wb_data;
  logic [2:0]    m_op;
  logic [4:0]    m_fd, m_wb_fd;
  logic [CW-1:0] m_count;
  logic          exp_ready;

  assign exp_ready = !flush && (!m_busy || (m_done && wb_ready));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_done <= 0; m_age <= 0; m_count <= '0;
      m_a <= '0; m_b <= '0; m_op <= '0; m_fd <= '0; m_wb_data <= '0; m_wb_fd <= '0;
    end else begin
      if (m_busy && m_done) begin
        if (wb_ready) begin
          m_count <= m_count + 1'b1;
          m_busy  <= 0;
          m_done  <= 0;
        end
      end else if (m_busy) begin
        if (flush) begin
          m_busy <= 0;
        end else begin
          m_age <= m_age + 1;
          if (m_age + 1 == int'(LAT)) begin
            m_done    <= 1;
            m_wb_data <= fpu_fn(m_a, m_b, m_op);
            m_wb_fd   <= m_fd;
          end
        end
      end
      if (req_valid && exp_ready) begin
        m_busy <= 1; m_done <= 0; m_age <= 0;
        m_a <= req_a; m_b <= req_b; m_op <= req_op; m_fd <= req_fd;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      check("wb_valid", {31'd0, wb_valid}, {31'd0, m_busy && m_done});
      check("wb_data", wb_data, m_wb_data);
      check("wb_fd", {27'd0, wb_fd}, {27'd0, m_wb_fd});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("hazard", {31'd0, chk_hazard}, {31'd0, m_busy && (chk_reg == m_fd)});
      check("op_count", {16'd0, op_count}, {16'd0, m_count});
      check("fpu_data1", fpu_data1, m_a);
      check("fpu_data2", fpu_data2, m_b);
      check("fpu_op", {29'd0, fpu_op}, {29'd0, m_op});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [4:0] fd);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_fd = fd;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_data1"}, fpu_data1, 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_count"}, {16'd0, op_count}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst0");
    reset = 1'b0;
    cmp_en = 1'b1;

    // Single op, latency 2.
    send(32'h42C80000, 32'h41C80000, 3'd0, 5'd3);
    step();
    req_valid = 1'b0;
    step();
    check("t1_early", {31'd0, wb_valid}, 32'd0);
    step();
    check("t1_valid", {31'd0, wb_valid}, 32'd1);
    check("t1_data", wb_data, 32'h42FA0000);
    check("t1_fd", {27'd0, wb_fd}, 32'd3);
    step();
    check("t1_count", {16'd0, op_count}, 32'd1);

    // Back-to-back: second op accepted on the first handshake.
    send(32'h3F800000, 32'h3F800000, 3'd0, 5'd4);
    step();
    send(32'hC1B80000, 32'hC5AF3800, 3'd0, 5'd5);
    step();
    step();
    check("t2_res1", wb_data, 32'h40000000);
    step();
    req_valid = 1'b0;
    check("t2_noidle", {31'd0, busy}, 32'd1);
    step();
    step();
    check("t2_res2", wb_data, 32'hC5AFF000);
    check("t2_fd2", {27'd0, wb_fd}, 32'd5);
    step();

    // Backpressure in WB with a pending request that must not be taken.
    wb_ready = 1'b0;
    send(32'h12345678, 32'h9ABCDEF0, 3'd3, 5'd6);
    step();
    send(32'h11111111, 32'h22222222, 3'd1, 5'd2);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("t3_ready", {31'd0, req_ready}, 32'd0);
      check("t3_data", wb_data, 32'hCCC4CCC7);
      check("t3_count", {16'd0, op_count}, 32'd3);
      step();
    end
    req_valid = 1'b0;
    wb_ready = 1'b1;
    step();
    check("t3_inc", {16'd0, op_count}, 32'd4);

    // Hazard tracking.
    send(32'h3F800000, 32'h3F800000, 3'd0, 5'd7);
    chk_reg = 5'd7;
    step();
    req_valid = 1'b0;
    check("t4_hit", {31'd0, chk_hazard}, 32'd1);
    chk_reg = 5'd8;
    #1;
    check("t4_miss", {31'd0, chk_hazard}, 32'd0);
    chk_reg = 5'd7;
    step();
    step();
    check("t4_wb_hit", {31'd0, chk_hazard}, 32'd1);
    step();
    check("t4_clear", {31'd0, chk_hazard}, 32'd0);

    // Flush in EXEC.
    send(32'h42C80000, 32'h41C80000, 3'd0, 5'd9);
    chk_reg = 5'd9;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_haz", {31'd0, chk_hazard}, 32'd0);
    check("t5_count", {16'd0, op_count}, 32'd5);
    repeat (3) step();
    // Flush in IDLE blocks acceptance.
    flush = 1'b1;
    send(32'h42C80000, 32'h41C80000, 3'd0, 5'd9);
    step();
    check("t5_idle", {31'd0, busy}, 32'd0);
    flush = 1'b0;
    req_valid = 1'b0;
    // Flush in WB: result completes, no new op taken.
    wb_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 3'd0, 5'd10);
    step();
    req_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    wb_ready = 1'b1;
    send(32'h42C80000, 32'h41C80000, 3'd0, 5'd11);
    #1;
    check("t5_wb_ready", {31'd0, req_ready}, 32'd0);
    step();
    check("t5_wb_count", {16'd0, op_count}, 32'd6);
    check("t5_wb_busy", {31'd0, busy}, 32'd0);
    flush = 1'b0;
    req_valid = 1'b0;

    // Asynchronous reset mid-EXEC, then mid-WB.
    send(32'h42C80000, 32'h41C80000, 3'd0, 5'd11);
    step();
    req_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_state("rst_exec");
    step();
    reset = 1'b0;
    wb_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 3'd0, 5'd12);
    step();
    req_valid = 1'b0;
    step();
    step();
    #1 reset = 1'b1;
    #1 check_reset_state("rst_wb");
    step();
    reset = 1'b0;
    wb_ready = 1'b1;
    send(32'h42C80000, 32'h41C80000, 3'd0, 5'd12);
    step();
    req_valid = 1'b0;
    step();
    step();
    check("t6_data", wb_data, 32'h42FA0000);
    check("t6_fd", {27'd0, wb_fd}, 32'd12);
    step();
    check("t6_count", {16'd0, op_count}, 32'd1);
    step();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
